// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the program-run sequencer.
//  - state_e     : sequencer states (3-bit encoding)
//  - DEF_*       : default phase lengths and dump window
//  - is_idle()   : true in the two resting states (IDLE, DONE)
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_INST = 3'd1,
    ST_LD_DATA = 3'd2,
    ST_CPU_RST = 3'd3,
    ST_RUN     = 3'd4,
    ST_DUMP_RD = 3'd5,
    ST_DUMP_TX = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  localparam int unsigned  DEF_INST_DEPTH    = 256;
  localparam int unsigned  DEF_DATA_LOAD_LEN = 1024;
  localparam logic [15:0]  DEF_DUMP_BASE     = 16'h0000;
  localparam int unsigned  DEF_DUMP_LEN      = 1024;
  localparam int unsigned  DEF_TIMEOUT       = 1000000;

  function automatic logic is_idle(state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_ram_port_mux.sv
// Combinational owner select for the instruction and data RAM ports.
//  host_owns=1 : host path (load/dump) drives address, data and write enable.
//  host_owns=0 : CPU drives the data RAM fully and the instruction RAM address;
//                instruction RAM is never written by the CPU.
// Ports: host_* (host side), cpu_* (CPU side), iram_* / dram_* (RAM side).
module cpu_run_ctrl_ram_port_mux (
  input  logic        host_owns,
  input  logic        host_iram_we,
  input  logic [7:0]  host_iram_addr,
  input  logic [7:0]  host_iram_din,
  input  logic        host_dram_we,
  input  logic [15:0] host_dram_addr,
  input  logic [7:0]  host_dram_din,
  input  logic        cpu_data_w,
  input  logic [15:0] cpu_addr_data,
  input  logic [7:0]  cpu_din_data,
  input  logic [7:0]  cpu_addr_inst,
  output logic        iram_we,
  output logic [7:0]  iram_addr,
  output logic [7:0]  iram_din,
  output logic        dram_we,
  output logic [15:0] dram_addr,
  output logic [7:0]  dram_din
);

  assign iram_we   = host_owns ? host_iram_we   : 1'b0;
  assign iram_addr = host_owns ? host_iram_addr : cpu_addr_inst;
  assign iram_din  = host_owns ? host_iram_din  : 8'h00;

  assign dram_we   = host_owns ? host_dram_we   : cpu_data_w;
  assign dram_addr = host_owns ? host_dram_addr : cpu_addr_data;
  assign dram_din  = host_owns ? host_dram_din  : cpu_din_data;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Program-run sequencer for cpu_top: loads instruction RAM then data RAM from
// the host byte stream, pulses CPU reset for one cycle, runs the CPU until it
// signals finish or the run budget expires, then streams a data-RAM window back.
// Ports:
//  clk, reset_n (async active-low), start (pulse)
//  rx_data/rx_valid/rx_ready  : host byte input (rx_ready combinational)
//  tx_data/tx_valid/tx_ready  : dumped byte output (registered, held until accepted)
//  cpu_enable/cpu_reset/cpu_finish, cpu_data_w/cpu_addr_data/cpu_din_data/cpu_addr_inst
//  iram_*/dram_* : RAM ports (dram_dout is synchronous, 1-cycle latency)
//  busy/done/timeout : status
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned INST_DEPTH    = DEF_INST_DEPTH,
  parameter int unsigned DATA_LOAD_LEN = DEF_DATA_LOAD_LEN,
  parameter logic [15:0] DUMP_BASE     = DEF_DUMP_BASE,
  parameter int unsigned DUMP_LEN      = DEF_DUMP_LEN,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_enable,
  output logic        cpu_reset,
  input  logic        cpu_finish,
  input  logic        cpu_data_w,
  input  logic [15:0] cpu_addr_data,
  input  logic [7:0]  cpu_din_data,
  input  logic [7:0]  cpu_addr_inst,
  output logic        dram_we,
  output logic [15:0] dram_addr,
  output logic [7:0]  dram_din,
  input  logic [7:0]  dram_dout,
  output logic        iram_we,
  output logic [7:0]  iram_addr,
  output logic [7:0]  iram_din,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam logic [15:0] INST_LAST = 16'(INST_DEPTH - 1);
  localparam logic [15:0] DATA_LAST = 16'(DATA_LOAD_LEN - 1);
  localparam logic [15:0] DUMP_LAST = 16'(DUMP_LEN - 1);
  localparam logic [31:0] RUN_LAST  = 32'(TIMEOUT - 1);
  localparam state_e AFTER_INST = (DATA_LOAD_LEN == 0) ? ST_CPU_RST : ST_LD_DATA;
  localparam state_e AFTER_RUN  = (DUMP_LEN == 0)      ? ST_DONE    : ST_DUMP_RD;

  state_e      state;
  logic [15:0] cnt;
  logic [31:0] run_cnt;
  // The read address is first presented on entry to DUMP_RD, so the first
  // byte needs one extra cycle there; later bytes are prefetched in DUMP_TX.
  logic        primed;

  logic        host_iram_we;
  logic        host_dram_we;
  logic [15:0] host_dram_addr;

  assign rx_ready = (state == ST_LD_INST) || (state == ST_LD_DATA);

  // NOTE: every signal written in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    host_iram_we   = (state == ST_LD_INST) && rx_valid;
    host_dram_we   = (state == ST_LD_DATA) && rx_valid;
    host_dram_addr = cnt;
    if (state == ST_DUMP_RD) host_dram_addr = DUMP_BASE + cnt;
    // While waiting on the host, read ahead the next byte of the window.
    if (state == ST_DUMP_TX) host_dram_addr = DUMP_BASE + cnt + 16'd1;
  end

  cpu_run_ctrl_ram_port_mux u_mux (
    .host_owns      (state != ST_RUN),
    .host_iram_we   (host_iram_we),
    .host_iram_addr (cnt[7:0]),
    .host_iram_din  (rx_data),
    .host_dram_we   (host_dram_we),
    .host_dram_addr (host_dram_addr),
    .host_dram_din  (rx_data),
    .cpu_data_w     (cpu_data_w),
    .cpu_addr_data  (cpu_addr_data),
    .cpu_din_data   (cpu_din_data),
    .cpu_addr_inst  (cpu_addr_inst),
    .iram_we        (iram_we),
    .iram_addr      (iram_addr),
    .iram_din       (iram_din),
    .dram_we        (dram_we),
    .dram_addr      (dram_addr),
    .dram_din       (dram_din)
  );

  // NOTE: only control state is reset here; the RAMs themselves are never
  // cleared, so an interrupted load leaves their contents as they were.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      run_cnt    <= '0;
      primed     <= 1'b0;
      cpu_reset  <= 1'b1;
      cpu_enable <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state and counters regardless of statement order.
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= ST_LD_INST;
          end
        end
        ST_LD_INST: begin
          if (rx_valid) begin
            if (cnt == INST_LAST) begin
              cnt   <= '0;
              state <= AFTER_INST;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_LD_DATA: begin
          if (rx_valid) begin
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= ST_CPU_RST;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_CPU_RST: begin
          run_cnt    <= '0;
          cpu_reset  <= 1'b0;
          cpu_enable <= 1'b1;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (cpu_finish || (run_cnt == RUN_LAST)) begin
            // finish takes priority: a finish on the last budget cycle is not a timeout
            if (!cpu_finish) timeout <= 1'b1;
            cpu_enable <= 1'b0;
            cpu_reset  <= 1'b1;
            cnt        <= '0;
            primed     <= 1'b0;
            done       <= (AFTER_RUN == ST_DONE);
            busy       <= (AFTER_RUN != ST_DONE);
            state      <= AFTER_RUN;
          end
        end
        ST_DUMP_RD: begin
          if (!primed) begin
            primed <= 1'b1;
          end else begin
            tx_data  <= dram_dout;
            tx_valid <= 1'b1;
            state    <= ST_DUMP_TX;
          end
        end
        ST_DUMP_TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (cnt == DUMP_LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              cnt   <= cnt + 16'd1;
              state <= ST_DUMP_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (is_idle(state) && !start) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl (INST_DEPTH=4, DATA_LOAD_LEN=2,
// DUMP_BASE=0x10, DUMP_LEN=2, TIMEOUT=50) with behavioural synchronous RAMs,
// plus a second instance with DATA_LOAD_LEN=0.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cpu_enable, cpu_reset;
  logic        cpu_finish = 1'b0;
  logic        cpu_data_w = 1'b0;
  logic [15:0] cpu_addr_data = 16'h0000;
  logic [7:0]  cpu_din_data = 8'h00;
  logic [7:0]  cpu_addr_inst = 8'h00;
  logic        dram_we, iram_we;
  logic [15:0] dram_addr;
  logic [7:0]  dram_din, dram_dout, iram_addr, iram_din;
  logic        busy, done, timeout;

  // second instance: no data-load phase
  logic        start_b = 1'b0;
  logic [7:0]  rx_data_b = 8'h00;
  logic        rx_valid_b = 1'b0;
  logic        rx_ready_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b;
  logic        cpu_enable_b, cpu_reset_b;
  logic        dram_we_b, iram_we_b;
  logic [15:0] dram_addr_b;
  logic [7:0]  dram_din_b, iram_addr_b, iram_din_b;
  logic        busy_b, done_b, timeout_b;
  logic [7:0]  zero8 = 8'h00;
  logic        zero1 = 1'b0;
  logic        one1  = 1'b1;
  logic [15:0] zero16 = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .INST_DEPTH(4), .DATA_LOAD_LEN(2), .DUMP_BASE(16'h0010), .DUMP_LEN(2), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_enable(cpu_enable), .cpu_reset(cpu_reset), .cpu_finish(cpu_finish),
    .cpu_data_w(cpu_data_w), .cpu_addr_data(cpu_addr_data),
    .cpu_din_data(cpu_din_data), .cpu_addr_inst(cpu_addr_inst),
    .dram_we(dram_we), .dram_addr(dram_addr), .dram_din(dram_din), .dram_dout(dram_dout),
    .iram_we(iram_we), .iram_addr(iram_addr), .iram_din(iram_din),
    .busy(busy), .done(done), .timeout(timeout)
  );

  cpu_run_ctrl #(
    .INST_DEPTH(4), .DATA_LOAD_LEN(0), .DUMP_BASE(16'h0010), .DUMP_LEN(2), .TIMEOUT(50)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(one1),
    .cpu_enable(cpu_enable_b), .cpu_reset(cpu_reset_b), .cpu_finish(zero1),
    .cpu_data_w(zero1), .cpu_addr_data(zero16),
    .cpu_din_data(zero8), .cpu_addr_inst(zero8),
    .dram_we(dram_we_b), .dram_addr(dram_addr_b), .dram_din(dram_din_b), .dram_dout(zero8),
    .iram_we(iram_we_b), .iram_addr(iram_addr_b), .iram_din(iram_din_b),
    .busy(busy_b), .done(done_b), .timeout(timeout_b)
  );

  // Behavioural RAMs: synchronous write, synchronous read with 1-cycle latency.
  logic [7:0] iram_m [256];
  logic [7:0] dram_m [65536];
  always @(posedge clk) if (iram_we) iram_m[iram_addr] <= iram_din;
  always @(posedge clk) begin
    if (dram_we) dram_m[dram_addr] <= dram_din;
    dram_dout <= dram_m[dram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the dump stream.
  logic [7:0] exp_q [$];
  logic [7:0] held_data = 8'h00;
  bit         held_valid = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      held_valid = 1'b0;
    end else if (tx_valid) begin
      if (held_valid) check("tx_data stable while stalled", tx_data, held_data);
      if (tx_ready) begin
        if (exp_q.size() == 0) check("tx byte was expected", exp_q.size(), 1);
        else check("tx byte", tx_data, exp_q.pop_front());
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_data  = tx_data;
      end
    end else if (held_valid) begin
      check("tx_valid held until accepted", tx_valid, 1);
      held_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    check("rx byte accepted", ok, 1);
  endtask

  task automatic load6(input logic [7:0] a0, a1, a2, a3, d0, d1);
    send_byte(a0); send_byte(a1); send_byte(a2); send_byte(a3);
    send_byte(d0); send_byte(d1);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_cycles;
    bit seen;

    // ---------------- reset state ----------------
    step(); step();
    @(negedge clk);
    check("rst cpu_reset", cpu_reset, 1);
    check("rst cpu_enable", cpu_enable, 0);
    check("rst rx_ready", rx_ready, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst timeout", timeout, 0);
    check("rst iram_we", iram_we, 0);
    check("rst dram_we", dram_we, 0);
    step();
    reset_n = 1'b1;
    step();

    // ---------------- 1: load ----------------
    pulse_start();
    @(negedge clk);
    check("t1 busy after start", busy, 1);
    check("t1 rx_ready in LD_INST", rx_ready, 1);
    step();
    load6(8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A);
    @(negedge clk);
    check("t1 CPU_RST cpu_reset", cpu_reset, 1);
    check("t1 CPU_RST cpu_enable", cpu_enable, 0);
    check("t1 CPU_RST rx_ready", rx_ready, 0);
    check("t1 iram[0]", iram_m[0], 8'h11);
    check("t1 iram[1]", iram_m[1], 8'h22);
    check("t1 iram[2]", iram_m[2], 8'h33);
    check("t1 iram[3]", iram_m[3], 8'h44);
    check("t1 dram[0]", dram_m[0], 8'hA5);
    check("t1 dram[1]", dram_m[1], 8'h5A);
    step();

    // ---------------- 2: run with finish at cycle 10 ----------------
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h77);
    for (int c = 0; c <= 10; c++) begin
      if (c == 2) begin cpu_data_w = 1'b1; cpu_addr_data = 16'h0010; cpu_din_data = 8'hC3; end
      if (c == 3) begin cpu_data_w = 1'b1; cpu_addr_data = 16'h0011; cpu_din_data = 8'h77; end
      if (c == 10) cpu_finish = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        check("t2 RUN cpu_enable", cpu_enable, 1);
        check("t2 RUN cpu_reset", cpu_reset, 0);
      end
      if (c == 2) begin
        check("t2 cpu write dram_we", dram_we, 1);
        check("t2 cpu write dram_addr", dram_addr, 16'h0010);
        check("t2 cpu write dram_din", dram_din, 8'hC3);
      end
      step();
      cpu_data_w = 1'b0;
      cpu_finish = 1'b0;
    end
    @(negedge clk);
    check("t2 cpu_enable low after finish", cpu_enable, 0);
    check("t2 cpu_reset high in dump", cpu_reset, 1);
    check("t2 no timeout", timeout, 0);
    wait_done("t2 reached DONE");
    check("t2 busy low in DONE", busy, 0);
    check("t2 all bytes dumped", exp_q.size(), 0);
    step();

    // ---------------- 3+4: timeout run, stalled dump ----------------
    pulse_start();
    @(negedge clk);
    check("t3 done cleared by start", done, 0);
    step();
    tx_ready = 1'b0;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h77);
    load6(8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A);
    run_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_enable) run_cycles++;
      else if (run_cycles > 0) break;
    end
    check("t3 RUN cycle count", run_cycles, 50);
    check("t3 timeout set", timeout, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (tx_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("t3 dump started", seen, 1);
    for (int i = 0; i < 7; i++) step();
    tx_ready = 1'b1;
    wait_done("t3 reached DONE");
    check("t3 timeout kept", timeout, 1);
    check("t3 all bytes dumped", exp_q.size(), 0);
    step();

    // ---------------- 5: reset mid LD_DATA ----------------
    pulse_start();
    @(negedge clk);
    check("t5 timeout cleared by start", timeout, 0);
    step();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hB6);
    #2 reset_n = 1'b0;
    #1;
    check("t5 rx_ready after reset", rx_ready, 0);
    check("t5 cpu_reset after reset", cpu_reset, 1);
    check("t5 busy after reset", busy, 0);
    check("t5 dram[1] untouched", dram_m[1], 8'h5A);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    pulse_start();
    load6(8'h01, 8'h02, 8'h03, 8'h04, 8'hB6, 8'h6B);
    check("t5 iram[0]", iram_m[0], 8'h01);
    check("t5 iram[3]", iram_m[3], 8'h04);
    check("t5 dram[0]", dram_m[0], 8'hB6);
    check("t5 dram[1]", dram_m[1], 8'h6B);
    step();

    // ---------------- 6: start / rx ignored in RUN ----------------
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h77);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    @(negedge clk);
    check("t6 rx_ready in RUN", rx_ready, 0);
    check("t6 iram_we in RUN", iram_we, 0);
    check("t6 dram_we in RUN", dram_we, 0);
    step();
    start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    check("t6 still running", cpu_enable, 1);
    check("t6 still busy", busy, 1);
    step();
    cpu_finish = 1'b1;
    step();
    cpu_finish = 1'b0;
    wait_done("t6 reached DONE");
    check("t6 no timeout", timeout, 0);
    check("t6 dram[0] unchanged", dram_m[0], 8'hB6);
    check("t6 all bytes dumped", exp_q.size(), 0);
    step();

    // ---------------- 6b: DATA_LOAD_LEN=0 ----------------
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      rx_data_b  = 8'(k + 1);
      rx_valid_b = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rx_ready_b) seen = 1'b1;
        step();
      end
      rx_valid_b = 1'b0;
      check("t6b rx byte accepted", seen, 1);
    end
    @(negedge clk);
    check("t6b CPU_RST rx_ready", rx_ready_b, 0);
    check("t6b CPU_RST cpu_reset", cpu_reset_b, 1);
    check("t6b CPU_RST busy", busy_b, 1);
    step();
    @(negedge clk);
    check("t6b RUN cpu_enable", cpu_enable_b, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
